// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared AXI4-Lite response codes and arbiter FSM encoding
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WADDR = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-requester round-robin grant decision (last = 1 means master 1 served last)
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/axi4_lite_arbiter_2to1.sv
// rtl/axi4_lite_arbiter_2to1.sv - two-master to one-slave AXI4-Lite arbiter, one transaction in flight
module axi4_lite_arbiter_2to1
    import axi4_lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  S0_AXI_AWVALID,
    input  logic [ADDR_WIDTH-1:0] S0_AXI_AWADDR,
    output logic                  S0_AXI_AWREADY,
    input  logic                  S0_AXI_WVALID,
    input  logic [DATA_WIDTH-1:0] S0_AXI_WDATA,
    input  logic [STRB_WIDTH-1:0] S0_AXI_WSTRB,
    output logic                  S0_AXI_WREADY,
    output logic                  S0_AXI_BVALID,
    output logic [1:0]            S0_AXI_BRESP,
    input  logic                  S0_AXI_BREADY,
    input  logic                  S0_AXI_ARVALID,
    input  logic [ADDR_WIDTH-1:0] S0_AXI_ARADDR,
    output logic                  S0_AXI_ARREADY,
    output logic                  S0_AXI_RVALID,
    output logic [1:0]            S0_AXI_RRESP,
    output logic [DATA_WIDTH-1:0] S0_AXI_RDATA,
    input  logic                  S0_AXI_RREADY,
    input  logic                  S1_AXI_AWVALID,
    input  logic [ADDR_WIDTH-1:0] S1_AXI_AWADDR,
    output logic                  S1_AXI_AWREADY,
    input  logic                  S1_AXI_WVALID,
    input  logic [DATA_WIDTH-1:0] S1_AXI_WDATA,
    input  logic [STRB_WIDTH-1:0] S1_AXI_WSTRB,
    output logic                  S1_AXI_WREADY,
    output logic                  S1_AXI_BVALID,
    output logic [1:0]            S1_AXI_BRESP,
    input  logic                  S1_AXI_BREADY,
    input  logic                  S1_AXI_ARVALID,
    input  logic [ADDR_WIDTH-1:0] S1_AXI_ARADDR,
    output logic                  S1_AXI_ARREADY,
    output logic                  S1_AXI_RVALID,
    output logic [1:0]            S1_AXI_RRESP,
    output logic [DATA_WIDTH-1:0] S1_AXI_RDATA,
    input  logic                  S1_AXI_RREADY,
    output logic                  M_AXI_AWVALID,
    output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
    input  logic                  M_AXI_AWREADY,
    output logic                  M_AXI_WVALID,
    output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic [STRB_WIDTH-1:0] M_AXI_WSTRB,
    input  logic                  M_AXI_WREADY,
    input  logic                  M_AXI_BVALID,
    input  logic [1:0]            M_AXI_BRESP,
    output logic                  M_AXI_BREADY,
    output logic                  M_AXI_ARVALID,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    input  logic                  M_AXI_ARREADY,
    input  logic                  M_AXI_RVALID,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
    output logic                  M_AXI_RREADY,
    output logic [1:0]            GRANT,
    output logic                  BUSY
);

    arb_state_t state, state_next;
    logic [1:0] grant, grant_next;
    logic       last, last_next;
    logic       aw_done, aw_done_next;
    logic       w_done, w_done_next;
    logic [1:0] req, arb_grant;
    logic       sel;
    logic       st_waddr, st_wresp, st_raddr, st_rdata;
    logic       g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;
    logic       aw_fin, w_fin;

    assign req = {S1_AXI_AWVALID | S1_AXI_ARVALID, S0_AXI_AWVALID | S0_AXI_ARVALID};

    rr_arbiter2 u_rr (
        .req   (req),
        .last  (last),
        .grant (arb_grant)
    );

    assign sel      = grant[1];
    assign st_waddr = (state == ST_WADDR);
    assign st_wresp = (state == ST_WRESP);
    assign st_raddr = (state == ST_RADDR);
    assign st_rdata = (state == ST_RDATA);

    assign g_awvalid = sel ? S1_AXI_AWVALID : S0_AXI_AWVALID;
    assign g_wvalid  = sel ? S1_AXI_WVALID  : S0_AXI_WVALID;
    assign g_bready  = sel ? S1_AXI_BREADY  : S0_AXI_BREADY;
    assign g_arvalid = sel ? S1_AXI_ARVALID : S0_AXI_ARVALID;
    assign g_rready  = sel ? S1_AXI_RREADY  : S0_AXI_RREADY;

    assign M_AXI_AWADDR = sel ? S1_AXI_AWADDR : S0_AXI_AWADDR;
    assign M_AXI_WDATA  = sel ? S1_AXI_WDATA  : S0_AXI_WDATA;
    assign M_AXI_WSTRB  = sel ? S1_AXI_WSTRB  : S0_AXI_WSTRB;
    assign M_AXI_ARADDR = sel ? S1_AXI_ARADDR : S0_AXI_ARADDR;

    // A done flag blocks re-forwarding of a channel whose handshake already happened
    assign M_AXI_AWVALID = st_waddr & g_awvalid & ~aw_done;
    assign M_AXI_WVALID  = st_waddr & g_wvalid & ~w_done;
    assign M_AXI_BREADY  = st_wresp & g_bready;
    assign M_AXI_ARVALID = st_raddr & g_arvalid;
    assign M_AXI_RREADY  = st_rdata & g_rready;

    assign S0_AXI_AWREADY = grant[0] & st_waddr & M_AXI_AWREADY & ~aw_done;
    assign S0_AXI_WREADY  = grant[0] & st_waddr & M_AXI_WREADY & ~w_done;
    assign S0_AXI_BVALID  = grant[0] & st_wresp & M_AXI_BVALID;
    assign S0_AXI_ARREADY = grant[0] & st_raddr & M_AXI_ARREADY;
    assign S0_AXI_RVALID  = grant[0] & st_rdata & M_AXI_RVALID;
    assign S1_AXI_AWREADY = grant[1] & st_waddr & M_AXI_AWREADY & ~aw_done;
    assign S1_AXI_WREADY  = grant[1] & st_waddr & M_AXI_WREADY & ~w_done;
    assign S1_AXI_BVALID  = grant[1] & st_wresp & M_AXI_BVALID;
    assign S1_AXI_ARREADY = grant[1] & st_raddr & M_AXI_ARREADY;
    assign S1_AXI_RVALID  = grant[1] & st_rdata & M_AXI_RVALID;

    assign S0_AXI_BRESP = M_AXI_BRESP;
    assign S1_AXI_BRESP = M_AXI_BRESP;
    assign S0_AXI_RRESP = M_AXI_RRESP;
    assign S1_AXI_RRESP = M_AXI_RRESP;
    assign S0_AXI_RDATA = M_AXI_RDATA;
    assign S1_AXI_RDATA = M_AXI_RDATA;

    assign aw_fin = aw_done | (M_AXI_AWVALID & M_AXI_AWREADY);
    assign w_fin  = w_done | (M_AXI_WVALID & M_AXI_WREADY);

    assign GRANT = grant;
    assign BUSY  = (state != ST_IDLE);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state   <= ST_IDLE;
            grant   <= 2'b00;
            last    <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_next;
            grant   <= grant_next;
            last    <= last_next;
            aw_done <= aw_done_next;
            w_done  <= w_done_next;
        end
    end

    always_comb begin
        state_next   = state;
        grant_next   = grant;
        last_next    = last;
        aw_done_next = aw_done;
        w_done_next  = w_done;
        case (state)
            ST_IDLE: begin
                grant_next = arb_grant;
                if (arb_grant != 2'b00) begin
                    // Write wins when the granted master offers both AW and AR
                    if (arb_grant[1] ? S1_AXI_AWVALID : S0_AXI_AWVALID)
                        state_next = ST_WADDR;
                    else
                        state_next = ST_RADDR;
                end
            end
            ST_WADDR: begin
                if (aw_fin && w_fin) begin
                    state_next   = ST_WRESP;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                end else begin
                    aw_done_next = aw_fin;
                    w_done_next  = w_fin;
                end
            end
            ST_WRESP: begin
                if (M_AXI_BVALID && M_AXI_BREADY) begin
                    state_next = ST_IDLE;
                    grant_next = 2'b00;
                    last_next  = grant[1];
                end
            end
            ST_RADDR: begin
                if (M_AXI_ARVALID && M_AXI_ARREADY)
                    state_next = ST_RDATA;
            end
            ST_RDATA: begin
                if (M_AXI_RVALID && M_AXI_RREADY) begin
                    state_next = ST_IDLE;
                    grant_next = 2'b00;
                    last_next  = grant[1];
                end
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_axi4_lite_arbiter_2to1.sv
// tb/tb_axi4_lite_arbiter_2to1.sv - directed self-checking bench for axi4_lite_arbiter_2to1
module tb_axi4_lite_arbiter_2to1;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;

    logic ACLK = 1'b0;
    logic ARESET;
    logic          S0_AXI_AWVALID, S0_AXI_AWREADY, S0_AXI_WVALID, S0_AXI_WREADY;
    logic [AW-1:0] S0_AXI_AWADDR, S0_AXI_ARADDR;
    logic [DW-1:0] S0_AXI_WDATA, S0_AXI_RDATA;
    logic [SW-1:0] S0_AXI_WSTRB;
    logic          S0_AXI_BVALID, S0_AXI_BREADY, S0_AXI_ARVALID, S0_AXI_ARREADY;
    logic          S0_AXI_RVALID, S0_AXI_RREADY;
    logic [1:0]    S0_AXI_BRESP, S0_AXI_RRESP;
    logic          S1_AXI_AWVALID, S1_AXI_AWREADY, S1_AXI_WVALID, S1_AXI_WREADY;
    logic [AW-1:0] S1_AXI_AWADDR, S1_AXI_ARADDR;
    logic [DW-1:0] S1_AXI_WDATA, S1_AXI_RDATA;
    logic [SW-1:0] S1_AXI_WSTRB;
    logic          S1_AXI_BVALID, S1_AXI_BREADY, S1_AXI_ARVALID, S1_AXI_ARREADY;
    logic          S1_AXI_RVALID, S1_AXI_RREADY;
    logic [1:0]    S1_AXI_BRESP, S1_AXI_RRESP;
    logic          M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
    logic [DW-1:0] M_AXI_WDATA, M_AXI_RDATA;
    logic [SW-1:0] M_AXI_WSTRB;
    logic          M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic          M_AXI_RVALID, M_AXI_RREADY;
    logic [1:0]    M_AXI_BRESP, M_AXI_RRESP;
    logic [1:0]    GRANT;
    logic          BUSY;

    int errors = 0;
    int checks = 0;
    int n_aw = 0;
    int n_w = 0;

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) begin
        if (M_AXI_AWVALID && M_AXI_AWREADY) n_aw <= n_aw + 1;
        if (M_AXI_WVALID && M_AXI_WREADY) n_w <= n_w + 1;
    end

    axi4_lite_arbiter_2to1 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S0_AXI_AWVALID(S0_AXI_AWVALID), .S0_AXI_AWADDR(S0_AXI_AWADDR), .S0_AXI_AWREADY(S0_AXI_AWREADY),
        .S0_AXI_WVALID(S0_AXI_WVALID), .S0_AXI_WDATA(S0_AXI_WDATA), .S0_AXI_WSTRB(S0_AXI_WSTRB),
        .S0_AXI_WREADY(S0_AXI_WREADY), .S0_AXI_BVALID(S0_AXI_BVALID), .S0_AXI_BRESP(S0_AXI_BRESP),
        .S0_AXI_BREADY(S0_AXI_BREADY), .S0_AXI_ARVALID(S0_AXI_ARVALID), .S0_AXI_ARADDR(S0_AXI_ARADDR),
        .S0_AXI_ARREADY(S0_AXI_ARREADY), .S0_AXI_RVALID(S0_AXI_RVALID), .S0_AXI_RRESP(S0_AXI_RRESP),
        .S0_AXI_RDATA(S0_AXI_RDATA), .S0_AXI_RREADY(S0_AXI_RREADY),
        .S1_AXI_AWVALID(S1_AXI_AWVALID), .S1_AXI_AWADDR(S1_AXI_AWADDR), .S1_AXI_AWREADY(S1_AXI_AWREADY),
        .S1_AXI_WVALID(S1_AXI_WVALID), .S1_AXI_WDATA(S1_AXI_WDATA), .S1_AXI_WSTRB(S1_AXI_WSTRB),
        .S1_AXI_WREADY(S1_AXI_WREADY), .S1_AXI_BVALID(S1_AXI_BVALID), .S1_AXI_BRESP(S1_AXI_BRESP),
        .S1_AXI_BREADY(S1_AXI_BREADY), .S1_AXI_ARVALID(S1_AXI_ARVALID), .S1_AXI_ARADDR(S1_AXI_ARADDR),
        .S1_AXI_ARREADY(S1_AXI_ARREADY), .S1_AXI_RVALID(S1_AXI_RVALID), .S1_AXI_RRESP(S1_AXI_RRESP),
        .S1_AXI_RDATA(S1_AXI_RDATA), .S1_AXI_RREADY(S1_AXI_RREADY),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BRESP(M_AXI_BRESP),
        .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARADDR(M_AXI_ARADDR),
        .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RREADY(M_AXI_RREADY),
        .GRANT(GRANT), .BUSY(BUSY)
    );

    task automatic clear_inputs();
        S0_AXI_AWVALID = 0; S0_AXI_AWADDR = '0; S0_AXI_WVALID = 0; S0_AXI_WDATA = '0; S0_AXI_WSTRB = '0;
        S0_AXI_BREADY = 0; S0_AXI_ARVALID = 0; S0_AXI_ARADDR = '0; S0_AXI_RREADY = 0;
        S1_AXI_AWVALID = 0; S1_AXI_AWADDR = '0; S1_AXI_WVALID = 0; S1_AXI_WDATA = '0; S1_AXI_WSTRB = '0;
        S1_AXI_BREADY = 0; S1_AXI_ARVALID = 0; S1_AXI_ARADDR = '0; S1_AXI_RREADY = 0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 2'b00;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RRESP = 2'b00; M_AXI_RDATA = '0;
    endtask

    task automatic do_reset();
        ARESET = 1;
        repeat (2) @(negedge ACLK);
        ARESET = 0;
    endtask

    task automatic test_reset();
        ARESET = 1;
        S0_AXI_AWVALID = 1; S0_AXI_ARVALID = 1; M_AXI_AWREADY = 1; M_AXI_ARREADY = 1;
        repeat (2) @(negedge ACLK);
        checks++; if (GRANT !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b want 00", GRANT); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", BUSY); end
        checks++; if ({M_AXI_AWVALID, M_AXI_ARVALID, S0_AXI_AWREADY, S0_AXI_ARREADY} !== 4'b0000) begin
            errors++; $display("FAIL rst_handshake: got %b want 0000",
                                {M_AXI_AWVALID, M_AXI_ARVALID, S0_AXI_AWREADY, S0_AXI_ARREADY});
        end
        clear_inputs();
        ARESET = 0;
        @(negedge ACLK);
        checks++; if (GRANT !== 2'b00) begin errors++; $display("FAIL rst_idle_grant: got %b want 00", GRANT); end
    endtask

    task automatic test_write_s0();
        S0_AXI_AWVALID = 1; S0_AXI_AWADDR = 32'h4; S0_AXI_WVALID = 1;
        S0_AXI_WDATA = 32'hDEADBEEF; S0_AXI_WSTRB = 4'hF;
        M_AXI_AWREADY = 1; M_AXI_WREADY = 1;
        #1;
        checks++; if ({GRANT, M_AXI_AWVALID} !== 3'b000) begin
            errors++; $display("FAIL wr_latency: got %b want 000", {GRANT, M_AXI_AWVALID}); end
        @(negedge ACLK);
        checks++; if (GRANT !== 2'b01) begin errors++; $display("FAIL wr_grant: got %b want 01", GRANT); end
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b want 1", BUSY); end
        checks++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB} !==
                      {2'b11, 32'h4, 32'hDEADBEEF, 4'hF}) begin
            errors++; $display("FAIL wr_fwd: got %b %b %h %h %h want 1 1 4 deadbeef f",
                               M_AXI_AWVALID, M_AXI_WVALID, M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB);
        end
        checks++; if ({S0_AXI_AWREADY, S0_AXI_WREADY, S1_AXI_AWREADY, S1_AXI_WREADY} !== 4'b1100) begin
            errors++; $display("FAIL wr_ready: got %b want 1100",
                               {S0_AXI_AWREADY, S0_AXI_WREADY, S1_AXI_AWREADY, S1_AXI_WREADY});
        end
        @(negedge ACLK);
        S0_AXI_AWVALID = 0; S0_AXI_WVALID = 0; M_AXI_AWREADY = 0; M_AXI_WREADY = 0;
        M_AXI_BVALID = 1; M_AXI_BRESP = 2'b00; S0_AXI_BREADY = 1; S1_AXI_BREADY = 1;
        #1;
        checks++; if ({S0_AXI_BVALID, S0_AXI_BRESP, S1_AXI_BVALID, M_AXI_BREADY} !== 5'b10001) begin
            errors++; $display("FAIL wr_bresp: got %b want 10001",
                               {S0_AXI_BVALID, S0_AXI_BRESP, S1_AXI_BVALID, M_AXI_BREADY});
        end
        @(negedge ACLK);
        checks++; if ({GRANT, BUSY} !== 3'b000) begin
            errors++; $display("FAIL wr_done_idle: got %b want 000", {GRANT, BUSY}); end
        clear_inputs();
    endtask

    task automatic test_rr_read();
        do_reset();
        S0_AXI_ARVALID = 1; S0_AXI_ARADDR = 32'h10; S1_AXI_ARVALID = 1; S1_AXI_ARADDR = 32'h20;
        M_AXI_ARREADY = 1;
        @(negedge ACLK);
        checks++; if (GRANT !== 2'b01) begin errors++; $display("FAIL rr_first: got %b want 01", GRANT); end
        checks++; if ({M_AXI_ARADDR, S0_AXI_ARREADY, S1_AXI_ARREADY} !== {32'h10, 2'b10}) begin
            errors++; $display("FAIL rr_ar0: got %h %b %b want 10 1 0", M_AXI_ARADDR, S0_AXI_ARREADY, S1_AXI_ARREADY);
        end
        @(negedge ACLK);
        S0_AXI_ARVALID = 0; M_AXI_RVALID = 1; M_AXI_RDATA = 32'hA5A50010; S0_AXI_RREADY = 1; S1_AXI_RREADY = 1;
        #1;
        checks++; if ({S0_AXI_RVALID, S1_AXI_RVALID, S0_AXI_RDATA} !== {2'b10, 32'hA5A50010}) begin
            errors++; $display("FAIL rr_r0: got %b %b %h want 1 0 a5a50010", S0_AXI_RVALID, S1_AXI_RVALID, S0_AXI_RDATA);
        end
        @(negedge ACLK);
        M_AXI_RVALID = 0;
        checks++; if (GRANT !== 2'b00) begin errors++; $display("FAIL rr_gap: got %b want 00", GRANT); end
        @(negedge ACLK);
        checks++; if (GRANT !== 2'b10) begin errors++; $display("FAIL rr_second: got %b want 10", GRANT); end
        checks++; if (M_AXI_ARADDR !== 32'h20) begin errors++; $display("FAIL rr_ar1: got %h want 20", M_AXI_ARADDR); end
        @(negedge ACLK);
        S1_AXI_ARVALID = 0; M_AXI_RVALID = 1;
        #1;
        checks++; if ({S1_AXI_RVALID, S0_AXI_RVALID} !== 2'b10) begin
            errors++; $display("FAIL rr_r1: got %b want 10", {S1_AXI_RVALID, S0_AXI_RVALID}); end
        @(negedge ACLK);
        clear_inputs();
    endtask

    task automatic test_write_first();
        S1_AXI_AWVALID = 1; S1_AXI_AWADDR = 32'h30; S1_AXI_WVALID = 1; S1_AXI_WDATA = 32'h12345678;
        S1_AXI_WSTRB = 4'h3; S1_AXI_ARVALID = 1; S1_AXI_ARADDR = 32'h40;
        M_AXI_AWREADY = 1; M_AXI_WREADY = 1; M_AXI_ARREADY = 1;
        @(negedge ACLK);
        checks++; if ({GRANT, M_AXI_AWVALID, M_AXI_ARVALID} !== 4'b1010) begin
            errors++; $display("FAIL wf_write: got %b want 1010", {GRANT, M_AXI_AWVALID, M_AXI_ARVALID}); end
        @(negedge ACLK);
        S1_AXI_AWVALID = 0; S1_AXI_WVALID = 0; M_AXI_BVALID = 1; S1_AXI_BREADY = 1;
        #1;
        checks++; if ({M_AXI_ARVALID, S1_AXI_BVALID} !== 2'b01) begin
            errors++; $display("FAIL wf_wresp: got %b want 01", {M_AXI_ARVALID, S1_AXI_BVALID}); end
        @(negedge ACLK);
        M_AXI_BVALID = 0;
        @(negedge ACLK);
        checks++; if ({GRANT, M_AXI_ARVALID, M_AXI_ARADDR} !== {3'b101, 32'h40}) begin
            errors++; $display("FAIL wf_read: got %b %b %h want 10 1 40", GRANT, M_AXI_ARVALID, M_AXI_ARADDR); end
        @(negedge ACLK);
        S1_AXI_ARVALID = 0; M_AXI_RVALID = 1; S1_AXI_RREADY = 1;
        @(negedge ACLK);
        clear_inputs();
    endtask

    task automatic test_split_write(input bit aw_first);
        int a0, w0;
        a0 = n_aw; w0 = n_w;
        S0_AXI_AWVALID = 1; S0_AXI_AWADDR = 32'h8; S0_AXI_WVALID = 1; S0_AXI_WDATA = 32'h0BADF00D;
        S0_AXI_WSTRB = 4'hC; M_AXI_AWREADY = aw_first; M_AXI_WREADY = !aw_first;
        @(negedge ACLK);
        checks++; if ({M_AXI_AWVALID, M_AXI_WVALID} !== 2'b11) begin
            errors++; $display("FAIL split_start: got %b want 11", {M_AXI_AWVALID, M_AXI_WVALID}); end
        repeat (2) begin
            @(negedge ACLK);
            checks++;
            if (aw_first ? ({M_AXI_AWVALID, S0_AXI_AWREADY, M_AXI_WVALID} !== 3'b001)
                         : ({M_AXI_WVALID, S0_AXI_WREADY, M_AXI_AWVALID} !== 3'b001)) begin
                errors++; $display("FAIL split_mask(aw_first=%0d): got aw %b/%b w %b/%b want done side 0",
                                   aw_first, M_AXI_AWVALID, S0_AXI_AWREADY, M_AXI_WVALID, S0_AXI_WREADY);
            end
        end
        M_AXI_AWREADY = 1; M_AXI_WREADY = 1;
        @(negedge ACLK);
        checks++; if ({M_AXI_AWVALID, M_AXI_WVALID} !== 2'b00) begin
            errors++; $display("FAIL split_wresp(aw_first=%0d): got %b want 00", aw_first, {M_AXI_AWVALID, M_AXI_WVALID}); end
        checks++; if ((n_aw - a0 != 1) || (n_w - w0 != 1)) begin
            errors++; $display("FAIL split_once(aw_first=%0d): got aw=%0d w=%0d want 1 1", aw_first, n_aw - a0, n_w - w0); end
        S0_AXI_AWVALID = 0; S0_AXI_WVALID = 0; M_AXI_AWREADY = 0; M_AXI_WREADY = 0;
        M_AXI_BVALID = 1; S0_AXI_BREADY = 1;
        #1;
        checks++; if ({S0_AXI_BVALID, M_AXI_BREADY} !== 2'b11) begin
            errors++; $display("FAIL split_b(aw_first=%0d): got %b want 11", aw_first, {S0_AXI_BVALID, M_AXI_BREADY}); end
        @(negedge ACLK);
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL split_idle: got %b want 0", BUSY); end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        logic [1:0] seq [10];
        int n, s0, s1;
        n = 0; s0 = 0; s1 = 0;
        do_reset();
        S0_AXI_ARVALID = 1; S1_AXI_ARVALID = 1; S0_AXI_RREADY = 1; S1_AXI_RREADY = 1;
        M_AXI_ARREADY = 1; M_AXI_RVALID = 1; M_AXI_RDATA = 32'h55AA55AA;
        for (int c = 0; c < 100 && n < 10; c++) begin
            @(negedge ACLK);
            if (M_AXI_RVALID && M_AXI_RREADY) begin
                seq[n] = GRANT;
                if (GRANT == 2'b01) s0++;
                if (GRANT == 2'b10) s1++;
                n++;
            end
        end
        S0_AXI_ARVALID = 0; S1_AXI_ARVALID = 0;
        checks++; if (n != 10) begin errors++; $display("FAIL b2b_timeout: got %0d want 10 transactions", n); end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (seq[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL b2b_alt[%0d]: got %b want %b", i, seq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
            end
        end
        checks++; if (s0 != 5 || s1 != 5) begin errors++; $display("FAIL b2b_fair: got %0d/%0d want 5/5", s0, s1); end
        @(negedge ACLK);
        clear_inputs();
        @(negedge ACLK);
    endtask

    task automatic test_reset_mid_rdata();
        S0_AXI_ARVALID = 1; S0_AXI_ARADDR = 32'h50; M_AXI_ARREADY = 1;
        @(negedge ACLK);
        @(negedge ACLK);
        S0_AXI_ARVALID = 0; M_AXI_RVALID = 1; S0_AXI_RREADY = 0;
        #1;
        checks++; if ({GRANT, BUSY, S0_AXI_RVALID, M_AXI_RREADY} !== 5'b01110) begin
            errors++; $display("FAIL mid_rdata: got %b want 01110", {GRANT, BUSY, S0_AXI_RVALID, M_AXI_RREADY}); end
        #2 ARESET = 1;
        #1;
        checks++; if ({GRANT, BUSY, S0_AXI_RVALID, M_AXI_RREADY, M_AXI_ARVALID} !== 6'b000000) begin
            errors++; $display("FAIL async_rst: got %b want 000000",
                               {GRANT, BUSY, S0_AXI_RVALID, M_AXI_RREADY, M_AXI_ARVALID}); end
        @(negedge ACLK);
        ARESET = 0; M_AXI_RVALID = 0;
        S0_AXI_ARVALID = 1; S1_AXI_ARVALID = 1; S0_AXI_ARADDR = 32'h60; S1_AXI_ARADDR = 32'h70;
        @(negedge ACLK);
        checks++; if ({GRANT, M_AXI_ARVALID, M_AXI_ARADDR} !== {3'b011, 32'h60}) begin
            errors++; $display("FAIL post_rst_arb: got %b %b %h want 01 1 60", GRANT, M_AXI_ARVALID, M_AXI_ARADDR); end
        @(negedge ACLK);
        S0_AXI_ARVALID = 0; M_AXI_RVALID = 1; S0_AXI_RREADY = 1;
        @(negedge ACLK);
        clear_inputs();
        @(negedge ACLK);
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_write_s0();
        test_rr_read();
        test_write_first();
        test_split_write(1'b1);
        test_split_write(1'b0);
        test_back_to_back();
        test_reset_mid_rdata();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
